als_responder: RTL and testbench
================================

# als_responder

Cycle-accurate model of the serial ambient-light sensor for the light-PWM design: the target device the sensor reader talks to. Samples the reader's `ncs`/`scl` on the system clock and shifts out a 16-slot frame carrying an 8-bit light value on `sda`. Used in simulation and in on-board loopback builds in place of the physical sensor.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `ncs` and `scl`. Legal values are 2..3.
- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-high
- `ncs`  in  1  chip select from the reader, active-low, asynchronous to `clk`
- `scl`  in  1  serial clock from the reader; idles low; asynchronous to `clk`
- `value`  in  8  light value to report; sampled once per frame
- `sda`  out  1  serial data to the reader
- `busy`  out  1  high from frame start until `ncs` deasserts
- `frame_done`  out  1  one-cycle pulse when slot 15 ends
- `err`  out  1  one-cycle short-frame pulse. Present only with `ALS_RESP_ERR_EN`.
- `err_cnt`  out  8  saturating short-frame count. Present only with `ALS_RESP_ERR_EN`.

## Operation
- `ncs` and `scl` each pass through `SYNC_STAGES` flops, plus one delay flop for edge detection.
- Events are taken from the synchronized signals:
  - `cs_fall`: `ncs` goes 1→0.
  - `cs_rise`: `ncs` goes 0→1.
  - `scl_fall`: `scl` goes 1→0 while `ncs`=0.
- Frame layout, slots 0..15:
  - slots 0–2: 0
  - slots 3–10: `value[7:0]`, MSB first
  - slots 11–15: 0
- State machine states are IDLE, SHIFT and DONE.
  - IDLE: `sda`=0 and `busy`=0. On `cs_fall`: latch `value` into `shreg`, set `slot`=0, go to SHIFT.
  - SHIFT: `sda` shows the bit for the current `slot`. On `scl_fall`, `slot` increments. On `scl_fall` with `slot`=15: pulse `frame_done`, go to DONE.
  - DONE: `sda`=0. On `cs_rise`, go to IDLE.
  - SHIFT + `cs_rise`: this is a short frame. Go to IDLE and pulse `err` if enabled. `frame_done` does not pulse.
- `value` changing mid-frame has no effect; only the value latched at `cs_fall` is sent.
- `cs_fall` while in SHIFT or DONE cannot occur, since `ncs` must rise first. A `cs_fall` in the same cycle as the `cs_rise` processing is impossible by construction.
- `scl_fall` events with `ncs`=1 are ignored.
- `slot` is a 4-bit counter. It never wraps, because SHIFT exits at 15.

## Timing
- Reset values: state IDLE, `sda`=0, `busy`=0, `frame_done`=0, `err`=0, `err_cnt`=0. Synchronizers are reset to `ncs`=1, `scl`=0.
- Reset asserted mid-frame aborts the frame. It does not count as an error.
- Latency from a pin edge to its event is `SYNC_STAGES`+1 cycles. `sda` updates on the cycle after the event, so the total is `SYNC_STAGES`+2 cycles (4 at default).
- `sda` is registered and glitch-free.
- Slot 0 is valid before the reader's first `scl` rise, provided `ncs`-fall to `scl`-rise is at least `SYNC_STAGES`+3 cycles.
- The reader samples on `scl` rising. The responder changes `sda` only after `scl` falling.
- Minimum `scl` half-period is `SYNC_STAGES`+3 cycles. A shorter half-period is outside the supported range.
- `busy` rises with the SHIFT entry cycle and falls with the IDLE entry cycle.

## Configuration
- `ALS_RESP_ERR_EN` defined:
  - `err` and `err_cnt` ports exist.
  - A short frame pulses `err` for one cycle and increments `err_cnt`, which saturates at 255.
- `ALS_RESP_ERR_EN` undefined:
  - The ports and counter are absent.
  - A short frame silently returns to IDLE.

## Structure
- Package `als_pkg` holds:
  - state encoding constants for IDLE, SHIFT and DONE
  - `ALS_FRAME_SLOTS`=16
  - `ALS_LEAD_ZEROS`=3
  - `ALS_DATA_BITS`=8
- One sub-module, `als_sync_edge`: a parameterized synchronizer plus edge detector with `rise`/`fall` outputs. It is instantiated for `ncs` and for `scl`.

## Test plan
- Reset, then drive `ncs`=1 and toggle `scl` → `sda`=0, `busy`=0, no `frame_done`.
- `value`=8'hA5, reader half-period 25 cycles, full 16-slot frame → bits sampled on rising edges are 000_10100101_00000. `frame_done` pulses once, after the 16th `scl` fall.
- `value`=8'h3C at `ncs` fall, changed to 8'hFF at slot 5 → the frame carries 8'h3C.
- `ncs` raised after 9 `scl` falls (with `ALS_RESP_ERR_EN`) → `err` pulses once, `err_cnt`=1, no `frame_done`, `busy`=0. The next full frame is correct.
- 300 short frames → `err_cnt` holds 255.
- `rst` pulsed at slot 7 → all outputs return to reset values. The next frame with `value`=8'h01 reads 000_00000001_00000.

Source files
------------

// File: rtl/als_pkg.sv
// als_pkg: shared constants, FSM state type and frame-bit helper
// for the ambient-light sensor responder model.
package als_pkg;

  localparam int ALS_FRAME_SLOTS = 16;
  localparam int ALS_LEAD_ZEROS  = 3;
  localparam int ALS_DATA_BITS   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } als_state_t;

  // Bit carried in a given slot: leading zeros, data MSB first,
  // then trailing zeros.
  function automatic logic als_slot_bit(
    input logic [ALS_DATA_BITS-1:0] d,
    input logic [3:0]               s
  );
    int   k;
    logic [2:0] idx;
    k = int'(s) - ALS_LEAD_ZEROS;
    if (k < 0 || k >= ALS_DATA_BITS) begin
      return 1'b0;
    end
    idx = 3'(ALS_DATA_BITS - 1 - k);
    return d[idx];
  endfunction

endpackage

// File: rtl/als_responder_if.sv
// als_responder_if: serial sensor bus (ncs, scl, sda).
// master = reader side, slave = responder side.
interface als_responder_if;
  logic ncs;
  logic scl;
  logic sda;

  modport master (
    output ncs,
    output scl,
    input  sda
  );

  modport slave (
    input  ncs,
    input  scl,
    output sda
  );
endinterface

// File: rtl/als_sync_edge.sv
// als_sync_edge: STAGES-deep synchronizer plus delay flop.
// Ports: clk, rst, i_d -> o_lvl (synced), o_rise, o_fall.
module als_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_dly  <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_dly  <= r_sync[STAGES-1];
    end
  end

  assign o_lvl  = r_sync[STAGES-1];
  assign o_rise =  r_sync[STAGES-1] & ~r_dly;
  assign o_fall = ~r_sync[STAGES-1] &  r_dly;

endmodule

// File: rtl/als_responder.sv
// als_responder: ambient-light sensor target model; shifts a
// 16-slot frame (3 zeros, value MSB first, 5 zeros) on bus.sda.
// Ports: clk, rst (sync, high), bus (slave), value, busy,
// frame_done; err/err_cnt only with ALS_RESP_ERR_EN.
module als_responder
  import als_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  als_responder_if.slave bus,
  input  logic [7:0] value,
  output logic       busy,
`ifdef ALS_RESP_ERR_EN
  output logic       frame_done,
  output logic       err,
  output logic [7:0] err_cnt
`else
  output logic       frame_done
`endif
);

  logic w_ncs_lvl;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_scl_fall_raw;
  logic w_scl_fall;

  als_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_ncs (
    .clk    (clk),
    .rst    (rst),
    .i_d    (bus.ncs),
    .o_lvl  (w_ncs_lvl),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  als_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_scl (
    .clk    (clk),
    .rst    (rst),
    .i_d    (bus.scl),
    .o_lvl  (),
    .o_rise (),
    .o_fall (w_scl_fall_raw)
  );

  assign w_scl_fall = w_scl_fall_raw & ~w_ncs_lvl;

  als_state_t r_state, w_state_nxt;
  logic [3:0] r_slot,  w_slot_nxt;
  logic [7:0] r_shreg, w_shreg_nxt;
  logic       r_sda,   w_sda_nxt;
  logic       r_fd,    w_fd_nxt;
`ifdef ALS_RESP_ERR_EN
  logic       r_err,   w_err_nxt;
  logic [7:0] r_err_cnt;
`endif

  localparam logic [3:0] LAST_SLOT = 4'(ALS_FRAME_SLOTS - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_slot  <= '0;
      r_shreg <= '0;
      r_sda   <= 1'b0;
      r_fd    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
      r_shreg <= w_shreg_nxt;
      r_sda   <= w_sda_nxt;
      r_fd    <= w_fd_nxt;
    end
  end

  // sda is registered from the next slot so it is stable
  // throughout each scl high phase.
  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_shreg_nxt = r_shreg;
    w_sda_nxt   = 1'b0;
    w_fd_nxt    = 1'b0;
`ifdef ALS_RESP_ERR_EN
    w_err_nxt   = 1'b0;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = ST_SHIFT;
          w_shreg_nxt = value;
          w_slot_nxt  = '0;
          w_sda_nxt   = als_slot_bit(value, 4'd0);
        end
      end
      ST_SHIFT: begin
        w_sda_nxt = als_slot_bit(r_shreg, r_slot);
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
          w_sda_nxt   = 1'b0;
`ifdef ALS_RESP_ERR_EN
          w_err_nxt   = 1'b1;
`endif
        end else if (w_scl_fall) begin
          if (r_slot == LAST_SLOT) begin
            w_state_nxt = ST_DONE;
            w_fd_nxt    = 1'b1;
            w_sda_nxt   = 1'b0;
          end else begin
            w_slot_nxt = r_slot + 4'd1;
            w_sda_nxt  = als_slot_bit(r_shreg, r_slot + 4'd1);
          end
        end
      end
      ST_DONE: begin
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef ALS_RESP_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_err <= w_err_nxt;
      if (w_err_nxt && r_err_cnt != 8'hFF) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign err     = r_err;
  assign err_cnt = r_err_cnt;
`endif

  assign bus.sda    = r_sda;
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = r_fd;

endmodule

// File: tb/tb_als_responder.sv
// tb_als_responder: randomized reader-side stimulus checked
// against a frame-level reference model.
module tb_als_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] value = 8'h00;
  logic       busy;
  logic       frame_done;
`ifdef ALS_RESP_ERR_EN
  logic       err;
  logic [7:0] err_cnt;
`endif

  als_responder_if bus();

  als_responder #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .value      (value),
    .busy       (busy),
`ifdef ALS_RESP_ERR_EN
    .frame_done (frame_done),
    .err        (err),
    .err_cnt    (err_cnt)
`else
    .frame_done (frame_done)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int fd_cnt   = 0;
  int err_pls  = 0;
  int m_err    = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
`ifdef ALS_RESP_ERR_EN
    if (err) err_pls++;
`endif
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One reader transaction: falls scl falling edges, then ncs up.
  // value switches to v2 after slot chg_at.
  task automatic frame(input logic [7:0] v,
                       input int falls,
                       input int hp,
                       input int chg_at,
                       input logic [7:0] v2);
    logic [15:0] word;
    logic [15:0] exp;
    int fd0;
    int e0;
    word  = '0;
    exp   = {3'b000, v, 5'b00000};
    fd0   = fd_cnt;
    e0    = err_pls;
    value = v;
    bus.ncs = 1'b0;
    cyc(hp);
    chk("busy_on", 32'(busy), 32'd1);
    for (int i = 0; i < falls; i++) begin
      word    = {word[14:0], bus.sda};
      bus.scl = 1'b1;
      cyc(hp);
      bus.scl = 1'b0;
      cyc(hp);
      if (i == chg_at) value = v2;
    end
    if (falls == 16) begin
      chk("data", 32'(word), 32'(exp));
      chk("sda_done", 32'(bus.sda), 32'd0);
    end else if (falls > 0) begin
      chk("part", 32'(word), 32'(exp >> (16 - falls)));
    end
    bus.ncs = 1'b1;
    cyc(hp);
    chk("busy_off", 32'(busy), 32'd0);
    chk("sda_idle", 32'(bus.sda), 32'd0);
    if (falls == 16) begin
      chk("fd_full", 32'(fd_cnt - fd0), 32'd1);
    end else begin
      chk("fd_short", 32'(fd_cnt - fd0), 32'd0);
      if (m_err < 255) m_err++;
`ifdef ALS_RESP_ERR_EN
      chk("err_pls", 32'(err_pls - e0), 32'd1);
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
`else
      chk("no_err", 32'(err_pls - e0), 32'd0);
`endif
    end
    cyc(4);
  endtask

  initial begin
    int ones;
    bus.ncs = 1'b1;
    bus.scl = 1'b0;
    cyc(4);
    chk("rst_sda", 32'(bus.sda), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
`ifdef ALS_RESP_ERR_EN
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ecnt", 32'(err_cnt), 32'd0);
`endif
    rst = 1'b0;
    cyc(4);

    // scl toggling with ncs high is ignored
    ones = 0;
    for (int i = 0; i < 20; i++) begin
      bus.scl = ~bus.scl;
      cyc(6);
      if (bus.sda) ones++;
      if (busy) ones++;
    end
    chk("idle_act", 32'(ones), 32'd0);
    chk("idle_fd", 32'(fd_cnt), 32'd0);

    frame(8'hA5, 16, 25, 99, 8'h00);
    frame(8'h3C, 16, 12, 5, 8'hFF);
    frame(8'h96, 9, 12, 99, 8'h00);
    frame(8'h5A, 16, 10, 99, 8'h00);

    for (int n = 0; n < 20; n++) begin
      int f;
      f = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 16;
      frame(8'($urandom), f, $urandom_range(8, 20),
            $urandom_range(0, 15), 8'($urandom));
    end

    for (int n = 0; n < 300; n++) begin
      frame(8'($urandom), $urandom_range(0, 2), 8, 99, 8'h00);
    end
`ifdef ALS_RESP_ERR_EN
    chk("ecnt_sat", 32'(err_cnt), 32'd255);
`endif

    // reset in the middle of a frame
    value   = 8'hC3;
    bus.ncs = 1'b0;
    cyc(10);
    for (int i = 0; i < 7; i++) begin
      bus.scl = 1'b1;
      cyc(10);
      bus.scl = 1'b0;
      cyc(10);
    end
    rst     = 1'b1;
    bus.ncs = 1'b1;
    cyc(2);
    chk("mrst_sda", 32'(bus.sda), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_fd", 32'(frame_done), 32'd0);
`ifdef ALS_RESP_ERR_EN
    chk("mrst_ecnt", 32'(err_cnt), 32'd0);
`endif
    m_err = 0;
    cyc(3);
    rst = 1'b0;
    cyc(10);
    frame(8'h01, 16, 15, 99, 8'h00);
    frame(8'h80, 4, 10, 99, 8'h00);
    frame(8'hFF, 16, 9, 2, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
